// File: rtl/sha256_miner_acc_pkg.sv
// Shared types, register map and SHA-256 helpers for the nonce-search accelerator.
package sha256_miner_acc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DISPATCH,
    S_WAIT,
    S_CHECK,
    S_DONE
  } acc_state_e;

  localparam int A_TARGET      = 16;
  localparam int A_NONCE_LO    = 24;
  localparam int A_NONCE_HI    = 25;
  localparam int A_CTRL        = 26;
  localparam int A_FOUND_NONCE = 27;
  localparam int A_HASH_COUNT  = 28;
  localparam int A_FOUND_HASH  = 32;

  localparam int B_START = 0;
  localparam int B_ABORT = 1;
  localparam int B_ACK   = 2;

  localparam logic [0:7][31:0] H_INIT = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [0:63][31:0] K_ROM = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_miner_acc_match.sv
// Priority comparator: lowest-index active core whose hash is below target wins.
module sha256_miner_acc_match #(
  parameter int N_CORES = 2,
  parameter int WIN_W   = 1
) (
  input  logic [N_CORES-1:0][255:0] i_hash,
  input  logic [N_CORES-1:0]        i_active,
  input  logic [255:0]              i_target,
  output logic                      o_hit,
  output logic [WIN_W-1:0]          o_win
);

  always_comb begin
    o_hit = 1'b0;
    o_win = '0;
    for (int i = N_CORES - 1; i >= 0; i--) begin
      if (i_active[i] && (i_hash[i] < i_target)) begin
        o_hit = 1'b1;
        o_win = WIN_W'(i);
      end
    end
  end

endmodule

// File: rtl/sha256_module.sv
// Single-block SHA-256 compression core, one round per clock (64 cycles per hash).
// done stays high and data_out stays stable until the next start or reset.
module sha256_module
  import sha256_miner_acc_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [511:0] data_in,
  output logic         done,
  output logic [255:0] data_out
);

  logic [7:0][31:0]  r_v;     // index 0 = a ... 7 = h
  logic [15:0][31:0] r_w;     // index 0 = W[t]
  logic [5:0]        r_round;
  logic              r_busy;
  logic              r_done;
  logic [31:0]       w_t1;
  logic [31:0]       w_t2;
  logic [31:0]       w_wnew;

  always_comb begin
    w_t1   = r_v[7] + bsig1(r_v[4]) + ((r_v[4] & r_v[5]) ^ (~r_v[4] & r_v[6])) + K_ROM[r_round] + r_w[0];
    w_t2   = bsig0(r_v[0]) + ((r_v[0] & r_v[1]) ^ (r_v[0] & r_v[2]) ^ (r_v[1] & r_v[2]));
    w_wnew = ssig1(r_w[14]) + r_w[9] + ssig0(r_w[1]) + r_w[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v     <= '0;
      r_w     <= '0;
      r_round <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (start) begin
      for (int i = 0; i < 8; i++) r_v[i] <= H_INIT[i];
      for (int j = 0; j < 16; j++) r_w[j] <= data_in[511-32*j -: 32];
      r_round <= '0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else if (r_busy) begin
      r_v     <= {r_v[6], r_v[5], r_v[4], r_v[3] + w_t1, r_v[2], r_v[1], r_v[0], w_t1 + w_t2};
      r_w     <= {w_wnew, r_w[15:1]};
      r_round <= r_round + 6'd1;
      if (r_round == 6'd63) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

  always_comb begin
    data_out = '0;
    for (int i = 0; i < 8; i++) data_out[255-32*i -: 32] = H_INIT[i] + r_v[i];
  end

  assign done = r_done;

endmodule

// File: rtl/sha256_miner_acc.sv
// Avalon-MM nonce-search accelerator: N_CORES SHA-256 cores hash consecutive nonces in batches
// until a hash below target is found or the inclusive nonce range is exhausted.
module sha256_miner_acc
  import sha256_miner_acc_pkg::*;
#(
  parameter int N_CORES    = 2,
  parameter int NONCE_WORD = 3,
  parameter int ADDR_W     = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chipselect,
  input  logic              write,
  input  logic              read,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       writedata,
  output logic [31:0]       data_out,
  output logic              irq
);

  localparam int WIN_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  acc_state_e r_state, w_state_nxt;
  logic [15:0][31:0] r_block;
  logic [7:0][31:0]  r_target, r_found_hash;
  logic [31:0] r_nonce_lo, r_nonce_hi, r_found_nonce, r_hash_count, r_data_out, w_rdata;
  logic [32:0] r_nonce_cur;
  logic [N_CORES-1:0] r_active, r_done_l, w_act, w_core_start, w_core_done;
  logic r_found, r_exhausted, r_aborted, r_core_rst;
  logic [N_CORES-1:0][32:0]  w_nonce;
  logic [N_CORES-1:0][511:0] w_core_data;
  logic [N_CORES-1:0][255:0] w_hash;
  logic [WIN_W-1:0] w_win;
  logic w_hit, w_wr, w_ctrl_wr, w_start, w_abort, w_ack, w_empty, w_last, w_all_done, w_busy, w_core_rst;
  int   w_addr;

  function automatic logic [31:0] count_ones(input logic [N_CORES-1:0] m);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < N_CORES; i++) n = n + 32'(m[i]);
    return n;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  assign w_addr     = int'(address);
  assign w_wr       = chipselect && write;
  assign w_ctrl_wr  = w_wr && (w_addr == A_CTRL);
  assign w_abort    = w_ctrl_wr && writedata[B_ABORT] && (r_state != S_IDLE);
  assign w_start    = w_ctrl_wr && writedata[B_START] && !writedata[B_ABORT] && (r_state == S_IDLE);
  assign w_ack      = w_ctrl_wr && writedata[B_ACK] && (r_state == S_DONE);
  assign w_empty    = r_nonce_cur > {1'b0, r_nonce_hi};
  assign w_last     = (r_nonce_cur + 33'(N_CORES)) > {1'b0, r_nonce_hi};
  assign w_all_done = ((r_done_l | w_core_done) & r_active) == r_active;
  assign w_busy     = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_core_rst = reset | r_core_rst;
  assign w_core_start = ((r_state == S_DISPATCH) && !w_abort) ? w_act : '0;

  // Per-core nonce, activity and block image with the nonce word substituted.
  always_comb begin
    w_nonce     = '0;
    w_act       = '0;
    w_core_data = '0;
    for (int i = 0; i < N_CORES; i++) begin
      w_nonce[i] = r_nonce_cur + 33'(i);
      w_act[i]   = w_nonce[i] <= {1'b0, r_nonce_hi};
      for (int j = 0; j < 16; j++)
        w_core_data[i][511-32*j -: 32] = (j == NONCE_WORD) ? w_nonce[i][31:0] : r_block[j];
    end
  end

  for (genvar g = 0; g < N_CORES; g++) begin : g_core
    sha256_module u_core (
      .clk      (clk),
      .reset    (w_core_rst),
      .start    (w_core_start[g]),
      .data_in  (w_core_data[g]),
      .done     (w_core_done[g]),
      .data_out (w_hash[g])
    );
  end

  sha256_miner_acc_match #(.N_CORES(N_CORES), .WIN_W(WIN_W)) u_match (
    .i_hash   (w_hash),
    .i_active (r_active),
    .i_target (r_target),
    .o_hit    (w_hit),
    .o_win    (w_win)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:     if (w_start) w_state_nxt = S_DISPATCH;
        S_DISPATCH: w_state_nxt = w_empty ? S_DONE : S_WAIT;
        S_WAIT:     if (w_all_done) w_state_nxt = S_CHECK;
        S_CHECK:    w_state_nxt = (w_hit || w_last) ? S_DONE : S_DISPATCH;
        S_DONE:     if (w_ack) w_state_nxt = S_IDLE;
        default:    w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_addr == A_NONCE_LO)         w_rdata = r_nonce_lo;
    else if (w_addr == A_NONCE_HI)    w_rdata = r_nonce_hi;
    else if (w_addr == A_CTRL)        w_rdata = {28'b0, w_busy, r_exhausted, r_found, r_aborted};
    else if (w_addr == A_FOUND_NONCE) w_rdata = r_found_nonce;
    else if (w_addr == A_HASH_COUNT)  w_rdata = r_hash_count;
    else if (w_addr >= A_FOUND_HASH && w_addr < A_FOUND_HASH + 8) w_rdata = r_found_hash[address[2:0]];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_block <= '0; r_target <= '0; r_found_hash <= '0;
      r_nonce_lo <= '0; r_nonce_hi <= '0; r_found_nonce <= '0; r_hash_count <= '0;
      r_data_out <= '0; r_nonce_cur <= '0; r_active <= '0; r_done_l <= '0;
      r_found <= 1'b0; r_exhausted <= 1'b0; r_aborted <= 1'b0; r_core_rst <= 1'b0;
    end else begin
      r_core_rst <= w_abort;
      if (chipselect && read) r_data_out <= w_rdata;
      if (w_wr && (r_state == S_IDLE)) begin
        if (w_addr < A_TARGET)           r_block[address[3:0]]  <= writedata;
        else if (w_addr < A_NONCE_LO)    r_target[address[2:0]] <= writedata;
        else if (w_addr == A_NONCE_LO)   r_nonce_lo <= writedata;
        else if (w_addr == A_NONCE_HI)   r_nonce_hi <= writedata;
      end
      if (w_abort) begin
        r_aborted <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: if (w_start) begin
            r_nonce_cur  <= {1'b0, r_nonce_lo};
            r_hash_count <= '0;
            r_found      <= 1'b0;
            r_exhausted  <= 1'b0;
            r_aborted    <= 1'b0;
          end
          S_DISPATCH: begin
            r_active <= w_act;
            r_done_l <= '0;
            if (w_empty) r_exhausted <= 1'b1;
          end
          S_WAIT: begin
            r_done_l <= r_done_l | (w_core_done & r_active);
            if (w_all_done) r_hash_count <= sat_add(r_hash_count, count_ones(r_active));
          end
          S_CHECK: begin
            if (w_hit) begin
              r_found       <= 1'b1;
              r_found_nonce <= r_nonce_cur[31:0] + 32'(w_win);
              r_found_hash  <= w_hash[w_win];
            end else if (w_last) begin
              r_exhausted <= 1'b1;
            end else begin
              r_nonce_cur <= r_nonce_cur + 33'(N_CORES);
            end
          end
          S_DONE: if (w_ack) begin
            r_found     <= 1'b0;
            r_exhausted <= 1'b0;
            r_aborted   <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign data_out = r_data_out;
  assign irq      = (r_state == S_DONE);

endmodule

// File: tb/tb_sha256_miner_acc.sv
// Directed bench for sha256_miner_acc using the "abc" test block and hand-derived results.
module tb_sha256_miner_acc;

  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              chipselect = 1'b0;
  logic              write = 1'b0;
  logic              read = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic [31:0]       writedata = '0;
  logic [31:0]       data_out;
  logic              irq;

  int n_checks = 0;
  int n_fail   = 0;

  // SHA-256("abc"), least significant word first (matches found_hash addresses 32..39).
  logic [31:0] abc_hash [8] = '{32'hf20015ad, 32'hb410ff61, 32'h96177a9c, 32'hb00361a3,
                                32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf};

  always #5 clk = ~clk;

  sha256_miner_acc #(.N_CORES(2), .NONCE_WORD(3), .ADDR_W(ADDR_W)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .chipselect (chipselect),
    .write      (write),
    .read       (read),
    .address    (address),
    .writedata  (writedata),
    .data_out   (data_out),
    .irq        (irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input int a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = ADDR_W'(a); writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic expect_reg(input string tag, input int a, input logic [31:0] exp);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = ADDR_W'(a);
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    chk(tag, data_out, exp);
  endtask

  task automatic set_target(input logic [31:0] v);
    for (int i = 0; i < 8; i++) bus_wr(16 + i, v);
  endtask

  task automatic set_range(input logic [31:0] lo, input logic [31:0] hi);
    bus_wr(24, lo);
    bus_wr(25, hi);
  endtask

  task automatic wait_irq(input string tag);
    int n;
    n = 0;
    while (irq !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(irq), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_dout", data_out, 32'd0);
    expect_reg("rst_status", 26, 32'h0);
    expect_reg("rst_hcount", 28, 32'h0);
    expect_reg("rst_fhash0", 32, 32'h0);

    // Single nonce, everything below an all-ones target.
    bus_wr(0, 32'h61626380);
    bus_wr(15, 32'h00000018);
    set_target(32'hFFFF_FFFF);
    set_range(32'd0, 32'd0);
    bus_wr(26, 32'h1);
    wait_irq("t1_irq");
    expect_reg("t1_status", 26, 32'h2);
    expect_reg("t1_fnonce", 27, 32'd0);
    expect_reg("t1_hcount", 28, 32'd1);
    for (int i = 0; i < 8; i++) expect_reg($sformatf("t1_fhash%0d", i), 32 + i, abc_hash[i]);
    bus_wr(26, 32'h4);
    chk("t1_ack_irq", 32'(irq), 32'd0);
    expect_reg("t1_ack_status", 26, 32'h0);

    // Unreachable target over 0..4: batches {0,1},{2,3},{4}.
    set_target(32'h0);
    set_range(32'd0, 32'd4);
    bus_wr(26, 32'h1);
    wait_irq("t2_irq");
    expect_reg("t2_status", 26, 32'h4);
    expect_reg("t2_hcount", 28, 32'd5);
    bus_wr(26, 32'h4);

    // Top of the 32-bit range must not wrap.
    set_range(32'hFFFF_FFFE, 32'hFFFF_FFFF);
    bus_wr(26, 32'h1);
    wait_irq("t3_irq");
    expect_reg("t3_status", 26, 32'h4);
    expect_reg("t3_hcount", 28, 32'd2);
    bus_wr(26, 32'h4);

    // Both cores hit in the first batch: the lower nonce wins.
    set_target(32'hFFFF_FFFF);
    set_range(32'd6, 32'd9);
    bus_wr(26, 32'h1);
    wait_irq("t4_irq");
    expect_reg("t4_status", 26, 32'h2);
    expect_reg("t4_fnonce", 27, 32'd6);
    expect_reg("t4_hcount", 28, 32'd2);
    bus_wr(26, 32'h4);

    // Start together with abort in IDLE does nothing.
    bus_wr(26, 32'h3);
    expect_reg("sa_status", 26, 32'h0);

    // Abort during WAIT, then a clean rerun.
    set_target(32'h0);
    set_range(32'd0, 32'd4);
    bus_wr(26, 32'h1);
    repeat (10) @(negedge clk);
    expect_reg("t5_busy", 26, 32'h8);
    bus_wr(26, 32'h2);
    expect_reg("t5_status", 26, 32'h1);
    chk("t5_irq", 32'(irq), 32'd0);
    set_target(32'hFFFF_FFFF);
    set_range(32'd0, 32'd0);
    bus_wr(26, 32'h1);
    wait_irq("t5_rerun_irq");
    expect_reg("t5_rerun_status", 26, 32'h2);
    expect_reg("t5_rerun_fnonce", 27, 32'd0);
    expect_reg("t5_rerun_hcount", 28, 32'd1);
    expect_reg("t5_rerun_fhash0", 32, abc_hash[0]);
    expect_reg("t5_rerun_fhash7", 39, abc_hash[7]);
    bus_wr(26, 32'h4);

    // Writes while busy are dropped.
    bus_wr(26, 32'h1);
    bus_wr(0, 32'hDEADBEEF);
    bus_wr(25, 32'd100);
    wait_irq("t6_irq");
    expect_reg("t6_fhash0", 32, abc_hash[0]);
    expect_reg("t6_fhash7", 39, abc_hash[7]);
    expect_reg("t6_nonce_hi", 25, 32'd0);
    bus_wr(26, 32'h4);

    // Empty range finishes immediately with no hashes.
    set_range(32'd5, 32'd3);
    bus_wr(26, 32'h1);
    wait_irq("t6_empty_irq");
    expect_reg("t6_empty_status", 26, 32'h4);
    expect_reg("t6_empty_hcount", 28, 32'd0);
    bus_wr(26, 32'h4);

    // Asynchronous reset in the middle of a search.
    set_target(32'h0);
    set_range(32'd2, 32'd7);
    bus_wr(26, 32'h1);
    repeat (10) @(negedge clk);
    expect_reg("t7_nonce_lo", 24, 32'd2);
    #3 reset = 1'b1;
    #1;
    chk("t7_rst_dout", data_out, 32'd0);
    chk("t7_rst_irq", 32'(irq), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    expect_reg("t7_status", 26, 32'h0);
    expect_reg("t7_nonce_lo", 24, 32'd0);
    expect_reg("t7_nonce_hi", 25, 32'd0);
    expect_reg("t7_hcount", 28, 32'd0);
    expect_reg("t7_fhash7", 39, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
